// File: rtl/wgt_buf_pkg.sv
// Shared types for the double-buffered weight SRAM controller.
//   bank_state_t : per-bank ownership (empty / holding a tile / being read)
//   rd_state_t   : read sequencer state, exported for debug/checkers
package wgt_buf_pkg;

  localparam int NUM_BANKS = 2;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FULL    = 2'd1,
    BANK_READING = 2'd2
  } bank_state_t;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_STREAM = 2'd1,
    RD_DRAIN  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/wgt_buf_rd_seq.sv
// Read sequencer for the weight buffer: read FSM, row counter and the
// RD_LAT-deep valid/last pipe that lines vec_valid/vec_last up with b_vec.
// Ports:
//   clk, rst           clock, async active-high reset
//   flush              sync abort: FSM to IDLE, pipe cleared, error cleared
//   ld_start           tile load request from the array
//   tile_ready         bank at the read pointer holds a complete tile
//   ld_stall           array back-pressure, suppresses issue in STREAM
//   rd_len             length of the tile in the bank being read
//   ld_accept          pulse: request accepted, bank becomes READING
//   rd_en, k_idx       SRAM read enable and row
//   vec_valid/last     b_vec qualifiers, RD_LAT cycles after issue
//   ld_done            pulse: tile fully emitted, bank may be released
//   err_underrun       sticky: request seen while idle with no tile
//   rd_state           current FSM state (debug)
module wgt_buf_rd_seq
  import wgt_buf_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ld_start,
  input  logic                  tile_ready,
  input  logic                  ld_stall,
  input  logic [ADDR_WIDTH:0]   rd_len,
  output logic                  ld_accept,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] k_idx,
  output logic                  vec_valid,
  output logic                  vec_last,
  output logic                  ld_done,
  output logic                  err_underrun,
  output rd_state_t             rd_state
);

  localparam logic [ADDR_WIDTH:0]   LEN_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] K_ONE   = 1;

  rd_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] k_q, k_d;
  logic [RD_LAT-1:0]     vld_q, vld_d;
  logic [RD_LAT-1:0]     lst_q, lst_d;
  logic                  err_q, err_d;
  logic                  last_issue;
  logic                  pipe_empty;

  always_comb begin
    rd_en      = (state_q == RD_STREAM) && !ld_stall && !flush;
    last_issue = rd_en && ({1'b0, k_q} == (rd_len - LEN_ONE));
    pipe_empty = (vld_q == '0);
    ld_accept  = (state_q == RD_IDLE) && ld_start && tile_ready && !flush;
    // Release only once the final vec_valid has left the pipe.
    ld_done    = (state_q == RD_DRAIN) && pipe_empty && !flush;

    state_d = state_q;
    k_d     = k_q;
    // A request while busy is dropped silently; only an idle miss is an error.
    err_d   = err_q || ((state_q == RD_IDLE) && ld_start && !tile_ready);

    vld_d    = vld_q << 1;
    vld_d[0] = rd_en;
    lst_d    = lst_q << 1;
    lst_d[0] = last_issue;

    case (state_q)
      RD_IDLE: begin
        if (ld_accept) begin
          state_d = RD_STREAM;
          k_d     = '0;
        end
      end
      RD_STREAM: begin
        if (rd_en) begin
          k_d = k_q + K_ONE;
          if (last_issue) state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (ld_done) state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase

    if (flush) begin
      state_d = RD_IDLE;
      k_d     = '0;
      err_d   = 1'b0;
      vld_d   = '0;
      lst_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RD_IDLE;
      k_q     <= '0;
      vld_q   <= '0;
      lst_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      vld_q   <= vld_d;
      lst_q   <= lst_d;
      err_q   <= err_d;
    end
  end

  assign k_idx        = k_q;
  assign vec_valid    = vld_q[RD_LAT-1];
  assign vec_last     = lst_q[RD_LAT-1];
  assign err_underrun = err_q;
  assign rd_state     = state_q;

endmodule

// File: rtl/wgt_buf_ctrl.sv
// Ping-pong controller for the two-bank weight SRAM. The DMA fills one bank
// while the systolic array drains the other; a bank only accepts writes when
// EMPTY, so a bank under read can never be written.
// Ports:
//   clk, rst, flush                       clock, async reset, sync abort
//   wr_valid, wr_last, wr_ready           DMA row handshake
//   we, waddr, bank_sel_wr                SRAM write side
//   ld_start, ld_stall                    array load request / back-pressure
//   tile_ready, ld_busy, ld_done          load status
//   rd_en, k_idx, bank_sel_rd             SRAM read side
//   vec_valid, vec_last                   b_vec qualifiers
//   bank_full, err_underrun               per-bank FULL flags, sticky error
// Handshake: a row transfers in exactly the cycles where wr_valid and
// wr_ready are both high; wr_ready does not depend on wr_valid, and the DMA
// holds the row and wr_last stable until it transfers.
module wgt_buf_ctrl
  import wgt_buf_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_valid,
  input  logic                  wr_last,
  output logic                  wr_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  bank_sel_wr,
  input  logic                  ld_start,
  input  logic                  ld_stall,
  output logic                  tile_ready,
  output logic                  ld_busy,
  output logic                  ld_done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] k_idx,
  output logic                  bank_sel_rd,
  output logic                  vec_valid,
  output logic                  vec_last,
  output logic [NUM_BANKS-1:0]  bank_full,
  output logic                  err_underrun
);

  localparam logic [ADDR_WIDTH:0]   LEN_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE = 1;

  bank_state_t           bank_q [NUM_BANKS];
  bank_state_t           bank_d [NUM_BANKS];
  logic [ADDR_WIDTH:0]   len_q  [NUM_BANKS];
  logic [ADDR_WIDTH:0]   len_d  [NUM_BANKS];
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic                  fill_close;
  logic                  ld_accept;
  rd_state_t             rd_state;

  assign wr_ready    = (bank_q[wr_bank_q] == BANK_EMPTY) && !flush;
  assign we          = wr_valid && wr_ready;
  assign waddr       = wr_cnt_q;
  assign bank_sel_wr = wr_bank_q;
  assign bank_sel_rd = rd_bank_q;
  assign tile_ready  = (bank_q[rd_bank_q] == BANK_FULL);
  assign ld_busy     = (rd_state != RD_IDLE);
  // A tile closes on wr_last or when the bank's last row is written.
  assign fill_close  = we && (wr_last || (wr_cnt_q == {ADDR_WIDTH{1'b1}}));

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) bank_full[b] = (bank_q[b] == BANK_FULL);
  end

  // Fill completion and read release can never touch the same bank in one
  // cycle (fill needs EMPTY, release needs READING), so both apply freely.
  always_comb begin
    bank_d    = bank_q;
    len_d     = len_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;

    if (we) begin
      if (fill_close) begin
        len_d[wr_bank_q]  = {1'b0, wr_cnt_q} + LEN_ONE;
        bank_d[wr_bank_q] = BANK_FULL;
        wr_cnt_d          = '0;
        wr_bank_d         = !wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + CNT_ONE;
      end
    end

    if (ld_accept) bank_d[rd_bank_q] = BANK_READING;

    if (ld_done) begin
      bank_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d         = !rd_bank_q;
    end

    if (flush) begin
      for (int b = 0; b < NUM_BANKS; b++) bank_d[b] = BANK_EMPTY;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
      wr_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_q[b] <= BANK_EMPTY;
        len_q[b]  <= '0;
      end
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
    end else begin
      bank_q    <= bank_d;
      len_q     <= len_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  wgt_buf_rd_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RD_LAT     (RD_LAT)
  ) u_rd_seq (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .ld_start     (ld_start),
    .tile_ready   (tile_ready),
    .ld_stall     (ld_stall),
    .rd_len       (len_q[rd_bank_q]),
    .ld_accept    (ld_accept),
    .rd_en        (rd_en),
    .k_idx        (k_idx),
    .vec_valid    (vec_valid),
    .vec_last     (vec_last),
    .ld_done      (ld_done),
    .err_underrun (err_underrun),
    .rd_state     (rd_state)
  );

endmodule
